// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned STATE_W        = 2;
  localparam int unsigned OPCODE_W       = 5;
  localparam int unsigned PERF_W_DEFAULT = 16;

  typedef enum logic [STATE_W-1:0] {
    RUN       = 2'd0,
    RDIR_WAIT = 2'd1,
    HALTED    = 2'd2
  } state_e;

  // Opcode recognised as halt by the decode/WB halt detector.
  localparam logic [OPCODE_W-1:0] HALT_OPCODE = 5'b00000;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/memory status inputs and per-stage latch/PC controls of pipe_ctrl.
interface pipe_ctrl_if;

  logic ex_ld_stall;
  logic dec_ld_stall;
  logic imem_busy;
  logic imem_done;
  logic dmem_busy;
  logic ex_redirect;
  logic wb_halt;

  logic pc_en;
  logic pc_redirect;
  logic if_id_en;
  logic id_ex_en;
  logic ex_mem_en;
  logic mem_wb_en;
  logic if_id_bubble;
  logic id_ex_bubble;
  logic ex_mem_bubble;
  logic mem_wb_bubble;
  logic fetch_squash;
  logic halted;

  // Pipeline side: supplies status, consumes controls.
  modport master (
    output ex_ld_stall, dec_ld_stall, imem_busy, imem_done, dmem_busy,
           ex_redirect, wb_halt,
    input  pc_en, pc_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_bubble, id_ex_bubble, ex_mem_bubble, mem_wb_bubble,
           fetch_squash, halted
  );

  // Sequencer side.
  modport slave (
    input  ex_ld_stall, dec_ld_stall, imem_busy, imem_done, dmem_busy,
           ex_redirect, wb_halt,
    output pc_en, pc_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_bubble, id_ex_bubble, ex_mem_bubble, mem_wb_bubble,
           fetch_squash, halted
  );

endinterface

// File: rtl/pipe_ctrl_perf.sv
// Saturating stall-cycle and accepted-redirect counters for pipe_ctrl.
module pipe_ctrl_perf #(
  parameter int unsigned PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_inc_i,
  input  logic              flush_inc_i,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o
);

  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc_i && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + PERF_W'(1);
    if (flush_inc_i && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: latch enables, bubbles, PC control.
// Define PIPE_CTRL_PERF_EN to build the stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned PERF_W = PERF_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  pipe_ctrl_if.slave        ctrl,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);

  state_e state_q, state_d;

  logic pc_en_c, pc_redirect_c, fetch_squash_c, halted_c;
  logic if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c;
  logic if_id_bubble_c, id_ex_bubble_c, ex_mem_bubble_c, mem_wb_bubble_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Outputs are purely combinational so decisions act on the current edge;
  // rst forces them low immediately rather than waiting for a clock.
  always_comb begin
    state_d         = state_q;
    pc_en_c         = 1'b0;
    pc_redirect_c   = 1'b0;
    fetch_squash_c  = 1'b0;
    halted_c        = 1'b0;
    if_id_en_c      = 1'b0;
    id_ex_en_c      = 1'b0;
    ex_mem_en_c     = 1'b0;
    mem_wb_en_c     = 1'b0;
    if_id_bubble_c  = 1'b0;
    id_ex_bubble_c  = 1'b0;
    ex_mem_bubble_c = 1'b0;
    mem_wb_bubble_c = 1'b0;

    if (rst) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (ctrl.wb_halt) begin
            state_d = HALTED;
          end else if (ctrl.dmem_busy) begin
            mem_wb_en_c     = 1'b1;
            mem_wb_bubble_c = 1'b1;
          end else if (ctrl.ex_ld_stall) begin
            ex_mem_en_c     = 1'b1;
            ex_mem_bubble_c = 1'b1;
            mem_wb_en_c     = 1'b1;
          end else if (ctrl.ex_redirect) begin
            // Decode instruction is squashed, so dec_ld_stall is irrelevant here.
            pc_en_c        = 1'b1;
            pc_redirect_c  = 1'b1;
            if_id_en_c     = 1'b1;
            id_ex_en_c     = 1'b1;
            ex_mem_en_c    = 1'b1;
            mem_wb_en_c    = 1'b1;
            if_id_bubble_c = 1'b1;
            id_ex_bubble_c = 1'b1;
            if (ctrl.imem_busy && !ctrl.imem_done) state_d = RDIR_WAIT;
          end else if (ctrl.dec_ld_stall) begin
            id_ex_en_c     = 1'b1;
            id_ex_bubble_c = 1'b1;
            ex_mem_en_c    = 1'b1;
            mem_wb_en_c    = 1'b1;
          end else if (ctrl.imem_busy) begin
            if_id_en_c     = 1'b1;
            if_id_bubble_c = 1'b1;
            id_ex_en_c     = 1'b1;
            ex_mem_en_c    = 1'b1;
            mem_wb_en_c    = 1'b1;
          end else begin
            pc_en_c     = 1'b1;
            if_id_en_c  = 1'b1;
            id_ex_en_c  = 1'b1;
            ex_mem_en_c = 1'b1;
            mem_wb_en_c = 1'b1;
          end
        end

        RDIR_WAIT: begin
          // Wrong-path fetch still in flight: drop it and keep IF/ID empty.
          fetch_squash_c = 1'b1;
          if (ctrl.wb_halt) begin
            state_d = HALTED;
          end else begin
            if_id_en_c     = 1'b1;
            if_id_bubble_c = 1'b1;
            if (ctrl.dmem_busy) begin
              mem_wb_en_c     = 1'b1;
              mem_wb_bubble_c = 1'b1;
            end else if (ctrl.ex_ld_stall) begin
              ex_mem_en_c     = 1'b1;
              ex_mem_bubble_c = 1'b1;
              mem_wb_en_c     = 1'b1;
            end else if (ctrl.dec_ld_stall) begin
              id_ex_en_c     = 1'b1;
              id_ex_bubble_c = 1'b1;
              ex_mem_en_c    = 1'b1;
              mem_wb_en_c    = 1'b1;
            end else begin
              id_ex_en_c  = 1'b1;
              ex_mem_en_c = 1'b1;
              mem_wb_en_c = 1'b1;
            end
            if (ctrl.imem_done) state_d = RUN;
          end
        end

        HALTED: begin
          halted_c = 1'b1;
        end

        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  assign ctrl.pc_en         = pc_en_c;
  assign ctrl.pc_redirect   = pc_redirect_c;
  assign ctrl.fetch_squash  = fetch_squash_c;
  assign ctrl.halted        = halted_c;
  assign ctrl.if_id_en      = if_id_en_c;
  assign ctrl.id_ex_en      = id_ex_en_c;
  assign ctrl.ex_mem_en     = ex_mem_en_c;
  assign ctrl.mem_wb_en     = mem_wb_en_c;
  assign ctrl.if_id_bubble  = if_id_bubble_c;
  assign ctrl.id_ex_bubble  = id_ex_bubble_c;
  assign ctrl.ex_mem_bubble = ex_mem_bubble_c;
  assign ctrl.mem_wb_bubble = mem_wb_bubble_c;

`ifdef PIPE_CTRL_PERF_EN
  logic stall_inc, flush_inc;

  // HALTED is excluded so both counters freeze once the pipeline stops.
  assign stall_inc = ((state_q == RUN) || (state_q == RDIR_WAIT)) && !pc_en_c;
  assign flush_inc = pc_redirect_c;

  pipe_ctrl_perf #(
    .PERF_W (PERF_W)
  ) u_perf (
    .clk         (clk),
    .rst         (rst),
    .stall_inc_i (stall_inc),
    .flush_inc_i (flush_inc),
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
